// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: QSPI PSRAM target model with a byte-wide backing memory.
// Bus inputs are resynchronised into clk; commands 0xEB (quad read) and 0x38 (quad
// write) are served, anything else is flagged and the rest of the transaction ignored.
module psram_qspi_responder #(
    parameter int MEM_ADDR_BITS = 10,
    parameter int WAIT_CYCLES   = 6,
    parameter int ADDR_WIDTH    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic [3:0] d_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam int         ADDR_NIBBLES = ADDR_WIDTH / 4;
    localparam int         MEM_DEPTH    = 1 << MEM_ADDR_BITS;
    localparam logic [7:0] CMD_READ     = 8'hEB;
    localparam logic [7:0] CMD_WRITE    = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    logic                     sck_meta_r, sck_sync_r, sck_prev_r;
    logic                     ce_meta_r, ce_sync_r, ce_prev_r;
    logic [3:0]               d_meta_r, d_sync_r;
    logic [1:0]               flush_cnt_r;
    logic                     armed_r;
    logic                     sck_rise_s, sck_fall_s, ce_fall_s, ce_rise_s;
    state_t                   state_r, state_next_s;
    logic                     cmd_bad_s;
    logic [7:0]               cnt_r, cmd_r, rd_shift_r, cmd_byte_s;
    logic [ADDR_WIDTH-1:0]    addr_r, addr_full_s;
    logic [MEM_ADDR_BITS-1:0] idx_r, idx_inc_s, addr_idx_s;
    logic [3:0]               wr_nib_r;
    logic                     nib_lo_r;
    logic [3:0]               d_out_r, d_oe_r;
    logic                     busy_r, cmd_err_r;
    logic                     mem_we_s;
    logic [7:0]               mem_r [MEM_DEPTH];

    // Two-flop synchronisers for the asynchronous bus, plus one history flop for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta_r <= 1'b0;
            sck_sync_r <= 1'b0;
            sck_prev_r <= 1'b0;
            ce_meta_r  <= 1'b1;
            ce_sync_r  <= 1'b1;
            ce_prev_r  <= 1'b1;
            d_meta_r   <= 4'h0;
            d_sync_r   <= 4'h0;
        end else begin
            sck_meta_r <= sck;
            sck_sync_r <= sck_meta_r;
            sck_prev_r <= sck_sync_r;
            ce_meta_r  <= ce_n;
            ce_sync_r  <= ce_meta_r;
            ce_prev_r  <= ce_sync_r;
            d_meta_r   <= d_in;
            d_sync_r   <= d_meta_r;
        end
    end

    // After reset, accept a new chip-select fall only once ce_n has really been seen high,
    // so a select held low across reset cannot fake a fresh transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_r <= 2'd0;
            armed_r     <= 1'b0;
        end else begin
            if (flush_cnt_r != 2'd2) begin
                flush_cnt_r <= flush_cnt_r + 2'd1;
            end
            if ((flush_cnt_r == 2'd2) && ce_sync_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign sck_rise_s  = sck_sync_r & ~sck_prev_r;
    assign sck_fall_s  = ~sck_sync_r & sck_prev_r;
    assign ce_fall_s   = armed_r & ce_prev_r & ~ce_sync_r;
    assign ce_rise_s   = ce_sync_r & ~ce_prev_r;
    assign cmd_byte_s  = {cmd_r[6:0], d_sync_r[0]};
    assign addr_full_s = (addr_r << 3'd4) | ADDR_WIDTH'(d_sync_r);
    assign addr_idx_s  = addr_full_s[MEM_ADDR_BITS-1:0];
    assign idx_inc_s   = idx_r + MEM_ADDR_BITS'(1'b1);
    assign mem_we_s    = (state_r == ST_WDATA) && sck_rise_s && !ce_rise_s && nib_lo_r && !rst;

    // Next-state logic; a chip-select release wins over every other transition.
    always_comb begin
        state_next_s = state_r;
        cmd_bad_s    = 1'b0;
        if (ce_rise_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ce_fall_s) state_next_s = ST_CMD;
                    else           state_next_s = ST_IDLE;
                end
                ST_CMD: begin
                    if (sck_rise_s && (cnt_r == 8'd7)) begin
                        if ((cmd_byte_s == CMD_READ) || (cmd_byte_s == CMD_WRITE)) begin
                            state_next_s = ST_ADDR;
                        end else begin
                            state_next_s = ST_IGNORE;
                            cmd_bad_s    = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s && (cnt_r == 8'(ADDR_NIBBLES - 1))) begin
                        if (cmd_r != CMD_READ) state_next_s = ST_WDATA;
                        else if (WAIT_CYCLES == 0) state_next_s = ST_RDATA;
                        else state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_WAIT: begin
                    if (sck_rise_s && (cnt_r == 8'(WAIT_CYCLES - 1))) state_next_s = ST_RDATA;
                    else                                               state_next_s = ST_WAIT;
                end
                ST_RDATA:  state_next_s = ST_RDATA;
                ST_WDATA:  state_next_s = ST_WDATA;
                ST_IGNORE: state_next_s = ST_IGNORE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Datapath: command/address shifting, wait counting, read nibble drive, write assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 8'd0;
            cmd_r      <= 8'd0;
            addr_r     <= '0;
            idx_r      <= '0;
            rd_shift_r <= 8'd0;
            wr_nib_r   <= 4'h0;
            nib_lo_r   <= 1'b0;
            d_out_r    <= 4'h0;
            d_oe_r     <= 4'h0;
            busy_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            busy_r    <= (state_next_s != ST_IDLE);
            cmd_err_r <= cmd_bad_s;
            if ((state_r == ST_IDLE) && ce_fall_s) begin
                cnt_r    <= 8'd0;
                cmd_r    <= 8'd0;
                addr_r   <= '0;
                idx_r    <= '0;
                nib_lo_r <= 1'b0;
            end else if (ce_rise_s) begin
                cnt_r    <= 8'd0;
                nib_lo_r <= 1'b0;
                d_out_r  <= 4'h0;
                d_oe_r   <= 4'h0;
            end else if (sck_rise_s) begin
                case (state_r)
                    ST_CMD: begin
                        cmd_r <= cmd_byte_s;
                        cnt_r <= (cnt_r == 8'd7) ? 8'd0 : cnt_r + 8'd1;
                    end
                    ST_ADDR: begin
                        addr_r <= addr_full_s;
                        if (cnt_r == 8'(ADDR_NIBBLES - 1)) begin
                            cnt_r      <= 8'd0;
                            idx_r      <= addr_idx_s;
                            rd_shift_r <= mem_r[addr_idx_s];
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    ST_WAIT: begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                    ST_WDATA: begin
                        if (!nib_lo_r) begin
                            wr_nib_r <= d_sync_r;
                            nib_lo_r <= 1'b1;
                        end else begin
                            idx_r    <= idx_inc_s;
                            nib_lo_r <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (sck_fall_s && (state_r == ST_RDATA)) begin
                d_oe_r <= 4'hF;
                if (!nib_lo_r) begin
                    d_out_r  <= rd_shift_r[7:4];
                    nib_lo_r <= 1'b1;
                end else begin
                    d_out_r    <= rd_shift_r[3:0];
                    idx_r      <= idx_inc_s;
                    rd_shift_r <= mem_r[idx_inc_s];
                    nib_lo_r   <= 1'b0;
                end
            end
        end
    end

    // Backing memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= {wr_nib_r, d_sync_r};
        end
    end

    assign d_out   = d_out_r;
    assign d_oe    = d_oe_r;
    assign busy    = busy_r;
    assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Testbench for psram_qspi_responder: directed QSPI transactions with a nibble
// scoreboard checked by a monitor on every controller sampling edge.
module tb_psram_qspi_responder;

    localparam int WAIT = 6;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sck  = 1'b0;
    logic       ce_n = 1'b1;
    logic [3:0] d_in = 4'h0;
    logic [3:0] d_out, d_oe;
    logic       busy, cmd_err;

    int         checks     = 0;
    int         errors     = 0;
    int         err_cycles = 0;
    int         e0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_nib;

    psram_qspi_responder dut (
        .clk     (clk),
        .rst     (rst),
        .sck     (sck),
        .ce_n    (ce_n),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_oe    (d_oe),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: controller samples on sck rise; driven nibbles pop the scoreboard, else bus must be quiet.
    always @(posedge sck) begin
        if (d_oe === 4'hF) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_nibble: got 0x%0h expected no driven data", d_out);
            end else begin
                exp_nib = exp_q.pop_front();
                check("read_nibble", {28'd0, d_out}, {28'd0, exp_nib});
            end
        end else begin
            check("quiet_bus", {24'd0, d_oe, d_out}, 32'h0);
        end
    end

    // Count clk cycles with cmd_err high.
    always @(posedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_cycle(input logic [3:0] nib);
        d_in = nib;
        clks(4);
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) bus_cycle({3'b000, c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) bus_cycle(a[i*4 +: 4]);
    endtask

    task automatic begin_xfer();
        ce_n = 1'b0;
        clks(4);
    endtask

    task automatic end_xfer(input string name);
        clks(4);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        ce_n = 1'b1;
        clks(8);
        check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({name, "_oe_end"}, {24'd0, d_oe, d_out}, 32'h0);
    endtask

    // Bytes are taken from the top of 'bytes', first byte in [31:24].
    task automatic write_bytes(input logic [23:0] a, input int n, input logic [31:0] bytes);
        logic [7:0] b;
        begin_xfer();
        send_cmd(8'h38);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            b = bytes[31-8*i -: 8];
            bus_cycle(b[7:4]);
            bus_cycle(b[3:0]);
        end
        end_xfer("write");
    endtask

    task automatic read_bytes(input logic [23:0] a, input int n, input logic [31:0] bytes);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[31-8*i -: 8];
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
        begin_xfer();
        send_cmd(8'hEB);
        send_addr(a);
        repeat (WAIT) bus_cycle(4'h0);
        repeat (2 * n) bus_cycle(4'h0);
        end_xfer("read");
        check("read_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        clks(3);
        check("rst_d_oe", {28'd0, d_oe}, 32'h0);
        check("rst_d_out", {28'd0, d_out}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        rst = 1'b0;
        clks(4);

        // Basic write then read back
        write_bytes(24'h000010, 2, 32'hA53C_0000);
        read_bytes(24'h000010, 2, 32'hA53C_0000);

        // Index wrap at top of memory on write and read
        write_bytes(24'h0003FF, 2, 32'h1122_0000);
        read_bytes(24'h0003FF, 2, 32'h1122_0000);
        read_bytes(24'h000000, 1, 32'h2200_0000);
        check("no_cmd_err_yet", err_cycles, 32'd0);

        // Unsupported command: one-cycle error pulse, rest of bus ignored
        e0 = err_cycles;
        begin_xfer();
        send_cmd(8'h9F);
        clks(4);
        check("cmd_err_pulse", err_cycles - e0, 32'd1);
        send_addr(24'h000010);
        bus_cycle(4'hF);
        bus_cycle(4'hF);
        end_xfer("ignore");
        read_bytes(24'h000010, 2, 32'hA53C_0000);

        // Incomplete write byte is discarded
        write_bytes(24'h000020, 1, 32'h5A00_0000);
        begin_xfer();
        send_cmd(8'h38);
        send_addr(24'h000020);
        bus_cycle(4'h7);
        end_xfer("partial");
        read_bytes(24'h000020, 1, 32'h5A00_0000);

        // Reset in the middle of a read
        write_bytes(24'h000040, 3, 32'h1234_5600);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        begin_xfer();
        send_cmd(8'hEB);
        send_addr(24'h000040);
        repeat (WAIT) bus_cycle(4'h0);
        repeat (2) bus_cycle(4'h0);
        clks(4);
        check("pre_rst_oe", {28'd0, d_oe}, 32'hF);
        check("pre_rst_drained", exp_q.size(), 32'd0);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("post_rst_oe", {24'd0, d_oe, d_out}, 32'h0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) bus_cycle(4'h0);
        clks(4);
        check("post_rst_no_restart", {31'd0, busy}, 32'd0);
        ce_n = 1'b1;
        clks(8);
        read_bytes(24'h000040, 3, 32'h1234_5600);

        // High address bits beyond the memory are ignored
        write_bytes(24'hFFF005, 1, 32'h7700_0000);
        read_bytes(24'h000005, 1, 32'h7700_0000);

        check("total_cmd_err_cycles", err_cycles, 32'd1);
        check("final_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
